cdc_pulse_rx_1bit: RTL and testbench

Receive end of the stretched-pulse, no-handshake 1-bit CDC path: takes the asynchronous stretched level produced in another clock domain, synchronizes it into `clk`, validates minimum high/low widths, and regenerates exactly one single-cycle pulse per accepted event. It also keeps a wrapping event counter and a sticky error flag for too-short (glitch) inputs. It sits in the destination domain, directly behind the source-side pulse stretcher.

---
 rtl/cdc_pulse_rx_1bit.sv | 169 ++++++++++++++++
 tb/tb_cdc_pulse_rx_1bit.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cdc_pulse_rx_1bit.sv
// Purpose : destination side of a stretched-pulse 1-bit CDC. Synchronizes async_d,
//           validates minimum high/low run widths, and regenerates exactly one
//           single-cycle pulse per accepted event. Also counts events and flags glitches.
// Latency : pulse_q rises SYNC_STAGES+MIN_HIGH edges after the first edge sampling async_d=1.
// Backpressure: none. The source must respect the minimum high/low widths.
//
// Ports:
//   clk       destination clock (only clock)
//   rst_n     asynchronous active-low reset
//   async_d   stretched level from the source domain (asynchronous)
//   clr_err   synchronous clear of err_short (a same-edge set wins)
//   pulse_q   one-cycle pulse per accepted event
//   level_q   synchronized async_d (last synchronizer stage)
//   evt_cnt   wrapping count of accepted events
//   err_short sticky flag: a high run shorter than MIN_HIGH was discarded
module cdc_pulse_rx_1bit #(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_HIGH    = 2,
  parameter int MIN_LOW     = 1,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             async_d,
  input  logic             clr_err,
  output logic             pulse_q,
  output logic             level_q,
  output logic [CNT_W-1:0] evt_cnt,
  output logic             err_short
);

  localparam int HW = (MIN_HIGH > 1) ? $clog2(MIN_HIGH + 1) : 1;
  localparam int LW = (MIN_LOW  > 1) ? $clog2(MIN_LOW  + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_HIGH_CHK = 2'd1,
    ST_ACTIVE   = 2'd2,
    ST_LOW_CHK  = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [HW-1:0]          r_hcnt;
  logic [HW-1:0]          w_hcnt_nxt;
  logic [HW-1:0]          w_hcnt_inc;
  logic [LW-1:0]          r_lcnt;
  logic [LW-1:0]          w_lcnt_nxt;
  logic [LW-1:0]          w_lcnt_inc;
  logic                   w_s;
  logic                   w_fire;
  logic                   w_set_err;
  logic                   r_pulse;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_err;

  // The only flop that samples async_d is r_sync[0].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], async_d};
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1];

  // Saturating increments. In practice the FSM leaves the check state on
  // reaching the limit, so saturation only guards against wrap.
  assign w_hcnt_inc = (r_hcnt == HW'(MIN_HIGH)) ? r_hcnt : r_hcnt + HW'(1);
  assign w_lcnt_inc = (r_lcnt == LW'(MIN_LOW))  ? r_lcnt : r_lcnt + LW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_hcnt  <= '0;
      r_lcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_hcnt  <= w_hcnt_nxt;
      r_lcnt  <= w_lcnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_hcnt_nxt  = r_hcnt;
    w_lcnt_nxt  = r_lcnt;
    w_fire      = 1'b0;
    w_set_err   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_s) begin
          if (MIN_HIGH == 1) begin
            w_state_nxt = ST_ACTIVE;
            w_fire      = 1'b1;
          end else begin
            w_state_nxt = ST_HIGH_CHK;
            w_hcnt_nxt  = HW'(1);
          end
        end
      end
      ST_HIGH_CHK: begin
        if (w_s) begin
          w_hcnt_nxt = w_hcnt_inc;
          if (w_hcnt_inc == HW'(MIN_HIGH)) begin
            w_state_nxt = ST_ACTIVE;
            w_fire      = 1'b1;
          end
        end else begin
          // High run too short: discard it and flag a glitch.
          w_set_err   = 1'b1;
          w_state_nxt = ST_IDLE;
          w_hcnt_nxt  = '0;
        end
      end
      ST_ACTIVE: begin
        if (!w_s) begin
          if (MIN_LOW == 1) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_LOW_CHK;
            w_lcnt_nxt  = LW'(1);
          end
        end
      end
      ST_LOW_CHK: begin
        if (!w_s) begin
          w_lcnt_nxt = w_lcnt_inc;
          if (w_lcnt_inc == LW'(MIN_LOW)) begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          // A short low dip is treated as part of the same event.
          w_state_nxt = ST_ACTIVE;
          w_lcnt_nxt  = '0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pulse <= 1'b0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_pulse <= w_fire;
      if (w_fire) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_set_err) begin
        r_err <= 1'b1;
      end else if (clr_err) begin
        r_err <= 1'b0;
      end
    end
  end

  assign pulse_q   = r_pulse;
  assign level_q   = w_s;
  assign evt_cnt   = r_cnt;
  assign err_short = r_err;

endmodule

// File: tb/tb_cdc_pulse_rx_1bit.sv
// Bench for cdc_pulse_rx_1bit: four instances with different parameters share
// one stimulus. A run-length model predicts every output on every cycle, and
// directed literal checks pin the model at the documented points.
module tb_cdc_pulse_rx_1bit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic async_d = 1'b0;
  logic clr_err = 1'b0;

  logic       pulse_w [4];
  logic       level_w [4];
  logic       err_w   [4];
  logic [7:0] cnt_w   [4];
  logic [1:0] cnt2;

  int errors = 0;
  int checks = 0;

  // Per-instance parameters: u0 defaults, u1 MIN_LOW=3, u2 CNT_W=2, u3 SYNC=3/MIN_HIGH=1
  int SY[4] = '{2, 2, 2, 3};
  int MH[4] = '{2, 2, 2, 1};
  int ML[4] = '{1, 3, 1, 1};
  int CW[4] = '{8, 8, 2, 8};

  always #5 clk = ~clk;

  cdc_pulse_rx_1bit #(.SYNC_STAGES(2), .MIN_HIGH(2), .MIN_LOW(1), .CNT_W(8)) u0 (
    .clk(clk), .rst_n(rst_n), .async_d(async_d), .clr_err(clr_err),
    .pulse_q(pulse_w[0]), .level_q(level_w[0]), .evt_cnt(cnt_w[0]), .err_short(err_w[0]));
  cdc_pulse_rx_1bit #(.SYNC_STAGES(2), .MIN_HIGH(2), .MIN_LOW(3), .CNT_W(8)) u1 (
    .clk(clk), .rst_n(rst_n), .async_d(async_d), .clr_err(clr_err),
    .pulse_q(pulse_w[1]), .level_q(level_w[1]), .evt_cnt(cnt_w[1]), .err_short(err_w[1]));
  cdc_pulse_rx_1bit #(.SYNC_STAGES(2), .MIN_HIGH(2), .MIN_LOW(1), .CNT_W(2)) u2 (
    .clk(clk), .rst_n(rst_n), .async_d(async_d), .clr_err(clr_err),
    .pulse_q(pulse_w[2]), .level_q(level_w[2]), .evt_cnt(cnt2), .err_short(err_w[2]));
  cdc_pulse_rx_1bit #(.SYNC_STAGES(3), .MIN_HIGH(1), .MIN_LOW(1), .CNT_W(8)) u3 (
    .clk(clk), .rst_n(rst_n), .async_d(async_d), .clr_err(clr_err),
    .pulse_q(pulse_w[3]), .level_q(level_w[3]), .evt_cnt(cnt_w[3]), .err_short(err_w[3]));

  assign cnt_w[2] = {6'b0, cnt2};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The model works on run lengths of the synchronized level: an event is
  // accepted when a high run reaches MIN_HIGH while armed; it re-arms after a
  // low run of MIN_LOW; an armed high run that ends early is a glitch.
  int m_sync  [4][3];
  int m_hrun  [4];
  int m_lrun  [4];
  int m_armed [4];
  int m_cnt   [4];
  int m_err   [4];
  int m_pulse [4];
  int m_level [4];

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 3; k++) m_sync[i][k] = 0;
      m_hrun[i] = 0; m_lrun[i] = 0; m_armed[i] = 1;
      m_cnt[i] = 0; m_err[i] = 0; m_pulse[i] = 0; m_level[i] = 0;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_reset();
    end else begin
      for (int i = 0; i < 4; i++) begin
        int s;
        int set_err;
        s = m_sync[i][SY[i]-1];
        m_pulse[i] = 0;
        set_err = 0;
        if (s != 0) begin
          m_hrun[i]++;
          m_lrun[i] = 0;
          if (m_armed[i] != 0 && m_hrun[i] == MH[i]) begin
            m_pulse[i] = 1;
            m_armed[i] = 0;
            m_cnt[i] = (m_cnt[i] + 1) % (1 << CW[i]);
          end
        end else begin
          set_err = (m_armed[i] != 0 && m_hrun[i] > 0 && m_hrun[i] < MH[i]) ? 1 : 0;
          m_hrun[i] = 0;
          m_lrun[i]++;
          if (m_armed[i] == 0 && m_lrun[i] >= ML[i]) m_armed[i] = 1;
        end
        if (set_err != 0) m_err[i] = 1;
        else if (clr_err) m_err[i] = 0;
        for (int k = SY[i]-1; k > 0; k--) m_sync[i][k] = m_sync[i][k-1];
        m_sync[i][0] = async_d ? 1 : 0;
        m_level[i] = m_sync[i][SY[i]-1];
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  int prev_pulse [4] = '{0, 0, 0, 0};

  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("u%0d.pulse_q", i), int'(pulse_w[i]), m_pulse[i]);
        chk($sformatf("u%0d.level_q", i), int'(level_w[i]), m_level[i]);
        chk($sformatf("u%0d.evt_cnt", i), int'(cnt_w[i]), m_cnt[i]);
        chk($sformatf("u%0d.err_short", i), int'(err_w[i]), m_err[i]);
        if (prev_pulse[i] != 0) chk($sformatf("u%0d.pulse_width", i), int'(pulse_w[i]), 0);
        prev_pulse[i] = int'(pulse_w[i]);
      end
    end else begin
      for (int i = 0; i < 4; i++) prev_pulse[i] = 0;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int h, input int l);
    async_d = 1'b1;
    repeat (h) tick();
    async_d = 1'b0;
    repeat (l) tick();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " pulse_q"}, int'(pulse_w[0]), 0);
    chk({tag, " level_q"}, int'(level_w[0]), 0);
    chk({tag, " evt_cnt"}, int'(cnt_w[0]), 0);
    chk({tag, " err_short"}, int'(err_w[0]), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) tick();
    chk_zero("reset");
    rst_n = 1'b1;
    repeat (3) tick();

    // Single valid event: high 6 cycles
    async_d = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk($sformatf("evt1 pulse k=%0d", k), int'(pulse_w[0]), (k == 4) ? 1 : 0);
      chk($sformatf("evt1 level k=%0d", k), int'(level_w[0]), (k >= 2 && k <= 7) ? 1 : 0);
      if (k == 6) async_d = 1'b0;
    end
    repeat (8) tick();
    chk("evt1 cnt", int'(cnt_w[0]), 1);
    chk("evt1 err", int'(err_w[0]), 0);

    // One-cycle glitch sets the sticky error
    async_d = 1'b1;
    tick();
    async_d = 1'b0;
    repeat (3) tick();
    chk("glitch err set", int'(err_w[0]), 1);
    chk("glitch cnt", int'(cnt_w[0]), 1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("glitch err clr", int'(err_w[0]), 0);
    repeat (4) tick();

    // Glitch abort on the same edge as clr_err: set wins
    async_d = 1'b1;
    clr_err = 1'b1;
    tick();
    async_d = 1'b0;
    repeat (3) tick();
    chk("set beats clr", int'(err_w[0]), 1);
    clr_err = 1'b0;
    tick();

    // Short low merges (u1), long low separates; u2 wraps 1,2,3,0,1
    run(5, 2);
    run(5, 10);
    chk("merge u1 cnt", int'(cnt_w[1]), 2);
    chk("merge u0 cnt", int'(cnt_w[0]), 3);
    run(5, 5);
    run(5, 10);
    chk("split u1 cnt", int'(cnt_w[1]), 4);
    chk("split u0 cnt", int'(cnt_w[0]), 5);
    chk("wrap u2 cnt", int'(cnt_w[2]), 1);
    chk("u3 cnt", int'(cnt_w[3]), 7);

    // Reset while in HIGH_CHK, release with async_d still high
    async_d = 1'b1;
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1 chk_zero("rst in high_chk");
    repeat (2) tick();
    rst_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk($sformatf("rel pulse k=%0d", k), int'(pulse_w[0]), (k == 4) ? 1 : 0);
      chk($sformatf("rel level k=%0d", k), int'(level_w[0]), (k >= 2) ? 1 : 0);
    end
    // Reset while pulse_q is high
    #1 rst_n = 1'b0;
    #1 chk("rst in pulse pulse_q", int'(pulse_w[0]), 0);
    chk("rst in pulse evt_cnt", int'(cnt_w[0]), 0);
    async_d = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();

    // Random-phase 2-cycle events separated by 2..5 low cycles
    for (int e = 0; e < 20; e++) begin
      #($urandom_range(0, 7));
      async_d = 1'b1;
      tick();
      tick();
      #($urandom_range(0, 7));
      async_d = 1'b0;
      repeat ($urandom_range(2, 5)) tick();
    end
    repeat (8) tick();
    chk("rand u3 cnt", int'(cnt_w[3]), 20);
    chk("rand u0 cnt", int'(cnt_w[0]), 20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
